mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Round-robin arbiter and sequencer for the shared 32-bit data-memory port. It grants one of three requesters access: 0 = load/store unit, 1 = instruction fetch, 2 = debug. It drives the 2-bit select that steers the external 3:1 address, write-data and byte-enable muxes in front of the memory. It runs the request/ready handshake with the memory and aborts stalled accesses with a timeout.

## Interface
Parameters:
- TIMEOUT, 255: maximum BUSY cycles waiting for mem_ready before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req  in  3  level request per requester; bit i = requester i.
- we  in  3  write-enable per requester; sampled with its req.
- sel  out  2  mux select: 2'h0/2'h1/2'h2 = requester 0/1/2; 2'h3 = idle, so the external muxes output 32'h0.
- mem_req  out  1  memory access valid.
- mem_we  out  1  write strobe for the granted access.
- mem_ready  in  1  memory completes the access this cycle.
- ack  out  3  one-cycle completion pulse to the granted requester.
- err  out  1  one-cycle pulse, coincident with ack, when the access was aborted by timeout.
- busy  out  1  high while in BUSY.

## Operation
- State machine with two states: IDLE and BUSY.
- Round-robin pointer ptr in {0,1,2}. Priority order is ptr, ptr+1, ptr+2 (mod 3).
- IDLE:
  - If any req bit is high, latch the highest-priority requester as owner and latch we[owner].
  - Go to BUSY at the next edge.
  - If no req bit is high, stay in IDLE.
- BUSY:
  - Outputs: sel=owner, mem_req=1, mem_we=latched we, busy=1.
  - The wait counter starts at 0 on BUSY entry and increments each BUSY cycle in which mem_ready=0.
  - Completion occurs when mem_ready=1. Then ack[owner]=1 combinationally in that same cycle and err=0.
  - Abort occurs when TIMEOUT!=0, the counter equals TIMEOUT and mem_ready=0. Then ack[owner]=1 and err=1 in that cycle.
  - On completion or abort, set ptr=(owner+1) mod 3.
  - On completion or abort, re-arbitrate in the same cycle with req[owner] masked. If another request is pending, go directly to BUSY with the new owner (no idle bubble). Otherwise go to IDLE.
- Requester rules:
  - Hold req, and constant address, data and we, until ack.
  - Drop req in the cycle after ack unless another access is wanted.
  - Masking guarantees at least one cycle between accesses by the same requester.
- If mem_ready is high while in IDLE, ignore it.
- Counter width is clog2(TIMEOUT+1). It never wraps, because the abort fires at TIMEOUT.

## Timing
- Reset values, applied immediately on rst_n low: state=IDLE, ptr=0, owner=0, counter=0. Outputs: sel=2'h3, mem_req=0, mem_we=0, ack=3'b000, err=0, busy=0.
- Reset mid-transaction: the access is dropped with no ack. The memory sees mem_req fall asynchronously.
- Latency: req sampled high at edge N gives mem_req=1 from cycle N+1.
  - With zero-wait memory (mem_ready=1 in the first BUSY cycle), ack occurs in cycle N+1.
  - Each wait state adds one cycle.
- Back-to-back grants to different requesters: sel changes at the completion edge and mem_req stays high continuously.
- Abort timing: with mem_ready held low, abort occurs in the (TIMEOUT+1)th BUSY cycle.
- sel, mem_req, mem_we and busy are registered state decodes. ack and err are combinational from state and mem_ready.

## Test plan
- Single access: req=3'b001, we=1, mem_ready held 1 → mem_req and sel=2'h0 in the next cycle; ack=3'b001 in the same cycle; IDLE after; ptr=1.
- Contention: req=3'b111 from reset, mem_ready=1, requesters drop req after ack → grants in order 0, 1, 2 on consecutive cycles; mem_req continuous for 3 cycles; then sel=2'h3.
- Fairness: requester 0 re-requests continuously with req=3'b101 → grants alternate 0, 2, 0, 2. Requester 0 is never granted twice in a row while 2 is pending.
- Wait states: mem_ready low for 3 cycles, then high → ack in the 4th BUSY cycle; err=0; sel stable throughout.
- Timeout: TIMEOUT=4, mem_ready held 0 → ack and err pulse in the 5th BUSY cycle; ptr advances; the next requester is served.
- Reset mid-access: assert rst_n=0 in the 2nd BUSY cycle → sel=2'h3, mem_req=0 immediately; no ack; after release, req=3'b010 is granted with ptr=0 order.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter and sequencer for the shared 32-bit data-memory port.
//   Requesters: 0 = load/store unit, 1 = instruction fetch, 2 = debug.
//   Drives the select for the external address/wdata/byte-enable muxes,
//   runs the mem_req/mem_ready handshake and aborts stalled accesses.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no access in flight, sel=3, waiting for any req
//   BUSY  | access for owner in flight, waiting for mem_ready/timeout
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req[2:0]   level request per requester
//   we[2:0]    write enable per requester, sampled with its req
//   sel[1:0]   mux select (0..2 = requester, 3 = idle)
//   mem_req    memory access valid
//   mem_we     write strobe for the granted access
//   mem_ready  memory completes the access this cycle
//   ack[2:0]   one-cycle completion pulse to the owner
//   err        one-cycle pulse with ack when the access timed out
//   busy       high while in BUSY
module mem_port_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [2:0] we,
  output logic [1:0] sel,
  output logic       mem_req,
  output logic       mem_we,
  input  logic       mem_ready,
  output logic [2:0] ack,
  output logic       err,
  output logic       busy
);

  // A zero TIMEOUT disables the abort; keep at least one counter bit so the
  // declarations stay legal.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nx;
  logic [1:0]      ptr, ptr_nx;
  logic [1:0]      owner, owner_nx;
  logic            owner_we, owner_we_nx;
  logic [CW-1:0]   cnt, cnt_nx;

  logic            complete;
  logic            found;
  logic [1:0]      pick;
  logic [1:0]      base;
  logic [2:0]      cand;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // First requester set in r, searching p, p+1, p+2 (mod 3).
  // Result is {found, index}.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    logic [1:0] i0, i1, i2;
    i0 = p;
    i1 = inc3(i0);
    i2 = inc3(i1);
    if (r[i0])      return {1'b1, i0};
    else if (r[i1]) return {1'b1, i1};
    else if (r[i2]) return {1'b1, i2};
    else            return 3'b000;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      owner    <= 2'd0;
      owner_we <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      owner    <= owner_nx;
      owner_we <= owner_we_nx;
      cnt      <= cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    ptr_nx      = ptr;
    owner_nx    = owner;
    owner_we_nx = owner_we;
    cnt_nx      = cnt;
    ack         = 3'b000;
    err         = 1'b0;
    complete    = 1'b0;
    cand        = req;
    base        = ptr;

    case (state)
      IDLE: begin
        cand = req;
        base = ptr;
      end
      BUSY: begin
        if (mem_ready) begin
          complete = 1'b1;
        end else if ((TIMEOUT != 0) && (cnt == TO_VAL)) begin
          complete = 1'b1;
          err      = 1'b1;
        end else if (TIMEOUT != 0) begin
          cnt_nx = cnt + 1'b1;
        end
        // Re-arbitrate from the advanced pointer with the finishing owner
        // masked, so the same requester never gets two grants in a row.
        cand = req & ~(3'b001 << owner);
        base = inc3(owner);
      end
      default: ;
    endcase

    {found, pick} = rr_pick(cand, base);

    if (complete) begin
      ack[owner] = 1'b1;
      ptr_nx     = base;
    end

    if ((state == IDLE) || complete) begin
      if (found) begin
        state_nx    = BUSY;
        owner_nx    = pick;
        owner_we_nx = we[pick];
        cnt_nx      = '0;
      end else begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    end
  end

  assign busy    = (state == BUSY);
  assign sel     = busy ? owner : 2'h3;
  assign mem_req = busy;
  assign mem_we  = busy & owner_we;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic [2:0] we = 3'b000;
  logic       mem_ready = 1'b0;
  logic [1:0] sel;
  logic       mem_req;
  logic       mem_we;
  logic [2:0] ack;
  logic       err;
  logic       busy;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [1:0] id;
    logic       err;
    logic       we;
  } exp_t;

  exp_t sb[$];

  // Per-cycle trace of the last traffic run.
  logic [1:0] tr_sel[64];
  logic       tr_mreq[64];
  logic       tr_busy[64];
  logic [2:0] tr_ack[64];
  logic       tr_err[64];
  int         tn;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .sel(sel),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ready(mem_ready),
    .ack(ack), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Scoreboard: every ack pops the expected grant.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && ack !== 3'b000) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_ack ack=%b err=%b sel=%0d", ack, err, sel);
      end else begin
        e = sb.pop_front();
        if (ack !== (3'b001 << e.id) || err !== e.err || sel !== e.id || mem_we !== e.we) begin
          bad++;
          $display("FAIL sb_grant got ack=%b err=%b sel=%0d we=%b want ack=%b err=%b sel=%0d we=%b",
                   ack, err, sel, mem_we, 3'b001 << e.id, e.err, e.id, e.we);
        end
      end
    end
  end

  task automatic push_exp(input logic [1:0] id, input logic e_err, input logic e_we);
    exp_t e;
    e.id = id; e.err = e_err; e.we = e_we;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 3'b000; we = 3'b000; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Requester i wants rem_i accesses; the memory inserts waitc wait states
  // per access. Records one trace entry per cycle, plus one after the last ack.
  task automatic run_traffic(input int r0, input int r1, input int r2,
                             input logic [2:0] wev, input int waitc, input int maxc);
    int rem[3];
    int bcnt;
    int c;
    bit fin;
    rem[0] = r0; rem[1] = r1; rem[2] = r2;
    bcnt = 0; tn = 0; fin = 0;
    for (c = 0; c < maxc && !fin; c++) begin
      @(negedge clk);
      if (rem[0] + rem[1] + rem[2] == 0) fin = 1;
      req = {rem[2] > 0, rem[1] > 0, rem[0] > 0};
      we = wev;
      mem_ready = busy && (bcnt >= waitc);
      #1;
      if (tn < 64) begin
        tr_sel[tn] = sel; tr_mreq[tn] = mem_req; tr_busy[tn] = busy;
        tr_ack[tn] = ack; tr_err[tn] = err;
        tn++;
      end
      if (ack !== 3'b000) begin
        for (int i = 0; i < 3; i++) if (ack[i] && rem[i] > 0) rem[i]--;
        bcnt = 0;
      end else if (busy) begin
        bcnt++;
      end else begin
        bcnt = 0;
      end
    end
    total++;
    if (!fin) begin
      bad++;
      $display("FAIL traffic_timeout remaining=%0d/%0d/%0d after %0d cycles", rem[0], rem[1], rem[2], maxc);
    end
    @(negedge clk);
    req = 3'b000; mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (sel !== 2'h3 || mem_req !== 1'b0 || mem_we !== 1'b0 || ack !== 3'b000 || err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs sel=%0d mem_req=%b mem_we=%b ack=%b err=%b busy=%b want 3/0/0/000/0/0",
               sel, mem_req, mem_we, ack, err, busy);
    end
    do_reset();
    mem_ready = 1'b1;
    #1;
    total++;
    if (ack !== 3'b000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_ready_ignored ack=%b busy=%b want 000/0", ack, busy);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    push_exp(2'd0, 1'b0, 1'b1);
    run_traffic(1, 0, 0, 3'b001, 0, 20);
    total++;
    if (tr_mreq[0] !== 1'b0 || tr_sel[0] !== 2'h3) begin
      bad++;
      $display("FAIL single_latency0 mem_req=%b sel=%0d want 0/3", tr_mreq[0], tr_sel[0]);
    end
    total++;
    if (tr_mreq[1] !== 1'b1 || tr_sel[1] !== 2'h0 || tr_ack[1] !== 3'b001) begin
      bad++;
      $display("FAIL single_grant mem_req=%b sel=%0d ack=%b want 1/0/001", tr_mreq[1], tr_sel[1], tr_ack[1]);
    end
    total++;
    if (tr_busy[2] !== 1'b0 || tr_sel[2] !== 2'h3) begin
      bad++;
      $display("FAIL single_idle_after busy=%b sel=%0d want 0/3", tr_busy[2], tr_sel[2]);
    end
    // ptr is now 1, so with 0 and 2 pending requester 2 wins first.
    push_exp(2'd2, 1'b0, 1'b0);
    push_exp(2'd0, 1'b0, 1'b1);
    run_traffic(1, 0, 1, 3'b001, 0, 20);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL single_sb_empty left=%0d want 0", sb.size());
    end
  endtask

  task automatic test_contention();
    do_reset();
    push_exp(2'd0, 1'b0, 1'b0);
    push_exp(2'd1, 1'b0, 1'b1);
    push_exp(2'd2, 1'b0, 1'b0);
    run_traffic(1, 1, 1, 3'b010, 0, 20);
    for (int i = 1; i <= 3; i++) begin
      total++;
      if (tr_mreq[i] !== 1'b1 || tr_sel[i] !== 2'(i - 1)) begin
        bad++;
        $display("FAIL contention_cycle%0d mem_req=%b sel=%0d want 1/%0d", i, tr_mreq[i], tr_sel[i], i - 1);
      end
    end
    total++;
    if (tr_sel[4] !== 2'h3 || tr_mreq[4] !== 1'b0) begin
      bad++;
      $display("FAIL contention_end sel=%0d mem_req=%b want 3/0", tr_sel[4], tr_mreq[4]);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    push_exp(2'd0, 1'b0, 1'b0);
    push_exp(2'd2, 1'b0, 1'b1);
    push_exp(2'd0, 1'b0, 1'b0);
    push_exp(2'd2, 1'b0, 1'b1);
    push_exp(2'd0, 1'b0, 1'b0);
    run_traffic(3, 0, 2, 3'b100, 0, 30);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL fairness_sb_empty left=%0d want 0", sb.size());
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    push_exp(2'd1, 1'b0, 1'b0);
    run_traffic(0, 1, 0, 3'b000, 3, 30);
    for (int i = 1; i <= 3; i++) begin
      total++;
      if (tr_sel[i] !== 2'h1 || tr_ack[i] !== 3'b000 || tr_busy[i] !== 1'b1) begin
        bad++;
        $display("FAIL wait_cycle%0d sel=%0d ack=%b busy=%b want 1/000/1", i, tr_sel[i], tr_ack[i], tr_busy[i]);
      end
    end
    total++;
    if (tr_ack[4] !== 3'b010 || tr_err[4] !== 1'b0 || tr_sel[4] !== 2'h1) begin
      bad++;
      $display("FAIL wait_ack ack=%b err=%b sel=%0d want 010/0/1", tr_ack[4], tr_err[4], tr_sel[4]);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    push_exp(2'd0, 1'b1, 1'b1);
    push_exp(2'd2, 1'b1, 1'b0);
    run_traffic(1, 0, 1, 3'b001, 100, 40);
    total++;
    if (tr_ack[4] !== 3'b000 || tr_busy[4] !== 1'b1) begin
      bad++;
      $display("FAIL timeout_early ack=%b busy=%b want 000/1", tr_ack[4], tr_busy[4]);
    end
    total++;
    if (tr_ack[5] !== 3'b001 || tr_err[5] !== 1'b1) begin
      bad++;
      $display("FAIL timeout_abort ack=%b err=%b want 001/1", tr_ack[5], tr_err[5]);
    end
    total++;
    if (tr_sel[6] !== 2'h2 || tr_mreq[6] !== 1'b1) begin
      bad++;
      $display("FAIL timeout_next sel=%0d mem_req=%b want 2/1", tr_sel[6], tr_mreq[6]);
    end
    total++;
    if (tr_ack[10] !== 3'b100 || tr_err[10] !== 1'b1) begin
      bad++;
      $display("FAIL timeout_abort2 ack=%b err=%b want 100/1", tr_ack[10], tr_err[10]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    req = 3'b001; we = 3'b001; mem_ready = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (busy !== 1'b1 || sel !== 2'h0) begin
      bad++;
      $display("FAIL midreset_busy busy=%b sel=%0d want 1/0", busy, sel);
    end
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (sel !== 2'h3 || mem_req !== 1'b0 || ack !== 3'b000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_async sel=%0d mem_req=%b ack=%b busy=%b want 3/0/000/0", sel, mem_req, ack, busy);
    end
    @(negedge clk);
    req = 3'b000;
    rst_n = 1'b1;
    push_exp(2'd1, 1'b0, 1'b0);
    push_exp(2'd2, 1'b0, 1'b0);
    run_traffic(0, 1, 1, 3'b000, 0, 20);
    total++;
    if (tr_sel[1] !== 2'h1 || tr_sel[2] !== 2'h2) begin
      bad++;
      $display("FAIL midreset_order sel=%0d,%0d want 1,2", tr_sel[1], tr_sel[2]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL final_sb_empty left=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
